// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
//  Module      : button_event
//  Description : Five-button event generator (press / release / long / repeat)
//                with per-button pending slots and an event FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module button_event #(
    parameter int TICK_DIV     = 100000,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] btn_db,
    output logic [4:0] held,
    output logic [4:0] press_pulse,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_btn,
    output logic [1:0] evt_type,
    output logic       overflow
);
    localparam int NUM_BTN = 5;
    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [1:0]       c_evtPress   = 2'd0;
    localparam logic [1:0]       c_evtRelease = 2'd1;
    localparam logic [1:0]       c_evtLong    = 2'd2;
    localparam logic [1:0]       c_evtRepeat  = 2'd3;
    localparam logic [PRE_W-1:0] c_preMax     = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]      c_holdTicks  = 16'(HOLD_TICKS);
    localparam logic [15:0]      c_rptTicks   = 16'(REPEAT_TICKS);
    localparam logic [AW:0]      c_fifoFull   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } btnState_t;

    logic [PRE_W-1:0]        r_preCnt;
    logic                    w_tick;
    logic [NUM_BTN-1:0]      r_btnPrev;
    logic [NUM_BTN-1:0]      w_rise;
    logic [NUM_BTN-1:0]      w_pressRaise;
    logic [NUM_BTN-1:0]      w_slotValid;
    logic [NUM_BTN-1:0][1:0] w_slotType;
    logic [NUM_BTN-1:0]      w_grant;
    logic [NUM_BTN-1:0]      w_drop;
    logic [NUM_BTN-1:0]      r_pressPulse;
    logic                    r_overflow;

    logic                    w_found;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic [2:0]              w_pushBtn;
    logic [1:0]              w_pushType;
    logic [AW:0]             r_count;
    logic [AW-1:0]           r_wrPtr;
    logic [AW-1:0]           r_rdPtr;
    logic [4:0]              r_mem [FIFO_DEPTH];
    logic [4:0]              w_head;

    // Timebase prescaler
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_preCnt <= '0;
        end else if (r_preCnt == c_preMax) begin
            r_preCnt <= '0;
        end else begin
            r_preCnt <= r_preCnt + 1'b1;
        end
    end

    assign w_tick = (r_preCnt == c_preMax);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_btnPrev    <= '0;
            r_pressPulse <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_btnPrev    <= btn_db;
            r_pressPulse <= w_pressRaise;
            r_overflow   <= r_overflow | (|w_drop);
        end
    end

    assign w_rise = btn_db & ~r_btnPrev;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btnState_t   r_state;
        btnState_t   w_stateNext;
        logic [15:0] r_cnt;
        logic [15:0] w_cntNext;
        logic        w_raise;
        logic [1:0]  w_type;
        logic        r_slotValid;
        logic [1:0]  r_slotType;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_stateNext;
                r_cnt   <= w_cntNext;
            end
        end

        // Release wins over a same-cycle tick, so LONG/REPEAT are suppressed.
        always_comb begin
            w_stateNext = r_state;
            w_cntNext   = r_cnt;
            w_raise     = 1'b0;
            w_type      = c_evtPress;
            case (r_state)
                IDLE: begin
                    if (w_rise[gi]) begin
                        w_stateNext = HOLD;
                        w_cntNext   = '0;
                        w_raise     = 1'b1;
                        w_type      = c_evtPress;
                    end
                end
                HOLD: begin
                    if (!btn_db[gi]) begin
                        w_stateNext = IDLE;
                        w_raise     = 1'b1;
                        w_type      = c_evtRelease;
                    end else if (w_tick) begin
                        if (r_cnt + 16'd1 == c_holdTicks) begin
                            w_stateNext = RPT;
                            w_cntNext   = '0;
                            w_raise     = 1'b1;
                            w_type      = c_evtLong;
                        end else begin
                            w_cntNext = r_cnt + 16'd1;
                        end
                    end
                end
                RPT: begin
                    if (!btn_db[gi]) begin
                        w_stateNext = IDLE;
                        w_raise     = 1'b1;
                        w_type      = c_evtRelease;
                    end else if (w_tick) begin
                        if (r_cnt + 16'd1 == c_rptTicks) begin
                            w_cntNext = '0;
                            w_raise   = 1'b1;
                            w_type    = c_evtRepeat;
                        end else begin
                            w_cntNext = r_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end
            endcase
        end

        // A slot being drained this cycle may accept the new event.
        assign w_drop[gi] = w_raise & r_slotValid & ~w_grant[gi];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_slotValid <= 1'b0;
                r_slotType  <= 2'd0;
            end else if (w_raise && !w_drop[gi]) begin
                r_slotValid <= 1'b1;
                r_slotType  <= w_type;
            end else if (w_grant[gi]) begin
                r_slotValid <= 1'b0;
            end
        end

        assign w_pressRaise[gi] = w_raise & (r_state == IDLE);
        assign w_slotValid[gi]  = r_slotValid;
        assign w_slotType[gi]   = r_slotType;
        assign held[gi]         = (r_state != IDLE);
    end

    assign evt_valid = (r_count != '0);
    assign w_full    = (r_count == c_fifoFull);
    assign w_pop     = evt_valid & evt_ready;

    always_comb begin
        w_found    = 1'b0;
        w_pushBtn  = 3'd0;
        w_pushType = c_evtPress;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!w_found && w_slotValid[i]) begin
                w_found    = 1'b1;
                w_pushBtn  = 3'(i);
                w_pushType = w_slotType[i];
            end
        end
    end

    assign w_push  = w_found & (~w_full | w_pop);
    assign w_grant = w_push ? (NUM_BTN'(1) << w_pushBtn) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= {w_pushBtn, w_pushType};
    end

    assign w_head      = r_mem[r_rdPtr];
    assign evt_btn     = evt_valid ? w_head[4:2] : 3'd0;
    assign evt_type    = evt_valid ? w_head[1:0] : 2'd0;
    assign press_pulse = r_pressPulse;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event
//  Description : Randomised + directed bench for button_event with a
//                queue-based reference model and decoupled scoreboard monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_event;
    localparam int TICK_DIV     = 4;
    localparam int HOLD_TICKS   = 3;
    localparam int REPEAT_TICKS = 2;
    localparam int FIFO_DEPTH   = 4;
    localparam int EXP_SIZE     = 8192;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] btnDb = '0;
    logic       evtReady = 1'b1;
    logic [4:0] held;
    logic [4:0] pressPulse;
    logic       evtValid;
    logic [2:0] evtBtn;
    logic [1:0] evtType;
    logic       overflow;

    button_event #(
        .TICK_DIV    (TICK_DIV),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_db     (btnDb),
        .held       (held),
        .press_pulse(pressPulse),
        .evt_valid  (evtValid),
        .evt_ready  (evtReady),
        .evt_btn    (evtBtn),
        .evt_type   (evtType),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state: behaviour in terms of modes, tick counts,
    // one pending event per button and an abstract FIFO occupancy.
    int         mMode  [5];
    int         mTicks [5];
    int         mPend  [5];
    int         mCnt;
    int         mCyc;
    logic       mOvf;
    logic [4:0] mHeld;
    logic [4:0] mPulse;
    logic [4:0] mPrev;
    logic [4:0] expMem [EXP_SIZE];
    int         wrIdx = 0;

    int         nCmp = 0;
    int         nFail = 0;
    int         rdIdx = 0;
    logic       doFinal = 1'b0;
    logic       finalDone = 1'b0;
    logic       prevStall = 1'b0;
    logic [4:0] prevHead = '0;

    always @(posedge clk or negedge rstn) begin
        bit tick;
        bit pop;
        int first;
        int ev;
        int limit;
        if (!rstn) begin
            for (int i = 0; i < 5; i++) begin
                mMode[i]  = 0;
                mTicks[i] = 0;
                mPend[i]  = -1;
            end
            mCnt   = 0;
            mCyc   = 0;
            mOvf   = 1'b0;
            mHeld  = '0;
            mPulse = '0;
            mPrev  = '0;
        end else begin
            tick = (mCyc % TICK_DIV) == TICK_DIV - 1;
            mCyc++;
            pop = (mCnt > 0) && evtReady;
            first = -1;
            for (int i = 4; i >= 0; i--) if (mPend[i] >= 0) first = i;
            if (first >= 0 && (mCnt < FIFO_DEPTH || pop)) begin
                if (wrIdx < EXP_SIZE) expMem[wrIdx] = {3'(first), 2'(mPend[first])};
                wrIdx++;
                mPend[first] = -1;
                mCnt++;
            end
            if (pop) mCnt--;
            mPulse = '0;
            for (int i = 0; i < 5; i++) begin
                ev = -1;
                if (mMode[i] == 0) begin
                    if (btnDb[i] && !mPrev[i]) begin
                        ev = 0; mMode[i] = 1; mTicks[i] = 0; mPulse[i] = 1'b1;
                    end
                end else if (!btnDb[i]) begin
                    ev = 1; mMode[i] = 0;
                end else if (tick) begin
                    mTicks[i]++;
                    limit = (mMode[i] == 1) ? HOLD_TICKS : REPEAT_TICKS;
                    if (mTicks[i] == limit) begin
                        ev = (mMode[i] == 1) ? 2 : 3;
                        mTicks[i] = 0;
                        mMode[i] = 2;
                    end
                end
                if (ev >= 0) begin
                    if (mPend[i] >= 0) mOvf = 1'b1;
                    else mPend[i] = ev;
                end
                mHeld[i] = (mMode[i] != 0);
            end
            mPrev = btnDb;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs between edges and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            rdIdx = wrIdx;
            check("reset_outputs", {20'd0, held, pressPulse, evtValid, evtBtn, evtType, overflow}, 32'd0);
            prevStall = 1'b0;
        end else begin
            check("held", {27'd0, held}, {27'd0, mHeld});
            check("press_pulse", {27'd0, pressPulse}, {27'd0, mPulse});
            check("evt_valid", {31'd0, evtValid}, {31'd0, (mCnt > 0)});
            check("overflow", {31'd0, overflow}, {31'd0, mOvf});
            if (prevStall && evtValid)
                check("head_stable", {27'd0, evtBtn, evtType}, {27'd0, prevHead});
            if (evtValid && evtReady) begin
                if (rdIdx >= wrIdx) begin
                    check("unexpected_event", {27'd0, evtBtn, evtType}, 32'hFFFF_FFFF);
                end else begin
                    check("event", {27'd0, evtBtn, evtType}, {27'd0, expMem[rdIdx % EXP_SIZE]});
                    rdIdx++;
                end
            end
            prevStall = evtValid && !evtReady;
            prevHead  = {evtBtn, evtType};
        end
        if (doFinal && !finalDone) begin
            check("all_events_drained", rdIdx, wrIdx);
            finalDone = 1'b1;
        end
    end

    task automatic drive(input logic [4:0] b, input logic r, input int n);
        btnDb    = b;
        evtReady = r;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [4:0] nb;
        logic       r;
        int         k;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        // Short press
        drive(5'b00001, 1'b1, 5);
        drive(5'b00000, 1'b1, 6);
        // Long hold with auto-repeat
        drive(5'b00100, 1'b1, 40);
        drive(5'b00000, 1'b1, 6);
        // Simultaneous press
        drive(5'b10011, 1'b1, 3);
        drive(5'b00000, 1'b1, 10);
        // Backpressure with drops
        for (int p = 0; p < 6; p++) begin
            drive(5'b01000, 1'b0, 1);
            drive(5'b00000, 1'b0, 2);
        end
        drive(5'b00000, 1'b1, 20);
        // Reset while button 1 is in auto-repeat
        drive(5'b00010, 1'b1, 30);
        rstn = 1'b0;
        drive(5'b00010, 1'b1, 2);
        rstn = 1'b1;
        drive(5'b00010, 1'b1, 6);
        drive(5'b00000, 1'b1, 6);
        // Release on the cycle whose tick would complete the long press
        drive(5'b00100, 1'b1, 1);
        k = 0;
        while (!(mMode[2] == 1 && mTicks[2] == HOLD_TICKS - 1 && (mCyc % TICK_DIV) == TICK_DIV - 1) && k < 40) begin
            drive(5'b00100, 1'b1, 1);
            k++;
        end
        drive(5'b00000, 1'b1, 8);

        // Randomised phase
        nb = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 15) == 0) nb[i] = ~nb[i];
            r = ((c % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 699) == 0) begin
                rstn = 1'b0;
                drive(nb, r, 2);
                rstn = 1'b1;
            end else begin
                drive(nb, r, 1);
            end
        end

        drive(5'b00000, 1'b1, 40);
        doFinal = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
